// File: rtl/spad_seq_if.sv
// Bundle of job-control, input stream, SPad port and consumer signals for spad_seq.
// The reuse field exists only when SPAD_SEQ_REUSE_EN is defined.
interface spad_seq_if #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 8
);
  logic               start;
  logic [A_WIDTH:0]   len;
`ifdef SPAD_SEQ_REUSE_EN
  logic [7:0]         reuse;
`endif
  logic               in_valid;
  logic               in_ready;
  logic [D_WIDTH-1:0] in_data;
  logic               spad_wen;
  logic [A_WIDTH-1:0] spad_w_addr;
  logic [D_WIDTH-1:0] spad_w_data;
  logic               spad_ren;
  logic [A_WIDTH-1:0] spad_r_addr;
  logic [D_WIDTH-1:0] spad_r_data;
  logic               out_ready;
  logic               out_valid;
  logic [D_WIDTH-1:0] out_data;
  logic               busy;
  logic               done;

`ifdef SPAD_SEQ_REUSE_EN
  modport slave (
    input  start, len, reuse, in_valid, in_data, spad_r_data, out_ready,
    output in_ready, spad_wen, spad_w_addr, spad_w_data, spad_ren, spad_r_addr,
           out_valid, out_data, busy, done
  );
  modport master (
    output start, len, reuse, in_valid, in_data, spad_r_data, out_ready,
    input  in_ready, spad_wen, spad_w_addr, spad_w_data, spad_ren, spad_r_addr,
           out_valid, out_data, busy, done
  );
`else
  modport slave (
    input  start, len, in_valid, in_data, spad_r_data, out_ready,
    output in_ready, spad_wen, spad_w_addr, spad_w_data, spad_ren, spad_r_addr,
           out_valid, out_data, busy, done
  );
  modport master (
    output start, len, in_valid, in_data, spad_r_data, out_ready,
    input  in_ready, spad_wen, spad_w_addr, spad_w_data, spad_ren, spad_r_addr,
           out_valid, out_data, busy, done
  );
`endif
endinterface

// File: rtl/spad_seq.sv
// spad_seq: fill a scratchpad from a stream, then replay it to a MAC; SPAD_SEQ_REUSE_EN adds multi-pass replay.
// Latency: SPad write in the same cycle as the input beat; out_valid exactly 2 cycles after each read issue.
// Backpressure: in_ready only while filling; reads issue only on out_ready, the output itself never stalls.
module spad_seq #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 8
) (
  input logic       clk,
  input logic       rst,
  spad_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, READ, DRAIN} state_t;

  localparam logic [A_WIDTH:0] ONE = {{A_WIDTH{1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [A_WIDTH:0]   len_q, w_cnt_q, r_cnt_q;
  logic               rd_pend_q, out_valid_q, done_q;
  logic [D_WIDTH-1:0] out_data_q;
  logic               fill_rdy, beat, issue;
  logic               w_last, r_last, last_pass, final_out;

`ifdef SPAD_SEQ_REUSE_EN
  logic [7:0] reuse_q, pass_q;
  assign last_pass = (pass_q == reuse_q);
`else
  assign last_pass = 1'b1;
`endif

  // Counters are one bit wider than the address so len = 2^A_WIDTH is reachable.
  assign w_last    = (w_cnt_q + ONE) == len_q;
  assign r_last    = (r_cnt_q + ONE) == len_q;
  assign final_out = (state_q == DRAIN) && out_valid_q && !rd_pend_q;

  always_comb begin
    state_d  = state_q;
    fill_rdy = 1'b0;
    beat     = 1'b0;
    issue    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && (bus.len != '0)) state_d = FILL;
      end
      FILL: begin
        fill_rdy = 1'b1;
        beat     = bus.in_valid;
        if (beat && w_last) state_d = READ;
      end
      READ: begin
        issue = bus.out_ready;
        if (issue && r_last && last_pass) state_d = DRAIN;
      end
      DRAIN: begin
        if (final_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      w_cnt_q     <= '0;
      r_cnt_q     <= '0;
      rd_pend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
`ifdef SPAD_SEQ_REUSE_EN
      reuse_q     <= '0;
      pass_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= issue;
      out_valid_q <= rd_pend_q;
      if (rd_pend_q) out_data_q <= bus.spad_r_data;
      // An empty job completes immediately with a single done pulse.
      done_q <= (state_q == IDLE) && bus.start && (bus.len == '0);
      if ((state_q == IDLE) && bus.start) begin
        len_q   <= bus.len;
        w_cnt_q <= '0;
        r_cnt_q <= '0;
`ifdef SPAD_SEQ_REUSE_EN
        reuse_q <= bus.reuse;
        pass_q  <= '0;
`endif
      end
      if (beat) w_cnt_q <= w_cnt_q + ONE;
      if (issue) begin
        if (r_last) begin
          r_cnt_q <= '0;
`ifdef SPAD_SEQ_REUSE_EN
          pass_q  <= pass_q + 8'd1;
`endif
        end else begin
          r_cnt_q <= r_cnt_q + ONE;
        end
      end
    end
  end

  assign bus.in_ready    = fill_rdy;
  assign bus.spad_wen    = beat;
  assign bus.spad_w_addr = w_cnt_q[A_WIDTH-1:0];
  assign bus.spad_w_data = beat ? bus.in_data : '0;
  assign bus.spad_ren    = issue;
  assign bus.spad_r_addr = r_cnt_q[A_WIDTH-1:0];
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q | final_out;
endmodule

// File: tb/tb_spad_seq.sv
// Bench for spad_seq: behavioural SPad memory, negedge monitor, queue-based expected streams.
`timescale 1ns/1ps
module tb_spad_seq;
  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;
`ifdef SPAD_SEQ_REUSE_EN
  localparam int REUSE_MAX = 3;
`else
  localparam int REUSE_MAX = 0;
`endif
  typedef logic [AW:0]   len_t;
  typedef logic [DW-1:0] word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, errors = 0, cyc = 0, start_cyc = 0, last_reuse = 0;
  int w_addr_q[$], iss_cyc_q[$], iss_addr_q[$], out_cyc_q[$], done_cyc_q[$];
  word_t w_data_q[$], out_dat_q[$];
  int overlap = 0, ren_no_rdy = 0, busy_cnt = 0, in_rdy_read = 0;
  word_t mem [DEPTH];

  spad_seq_if #(.D_WIDTH(DW), .A_WIDTH(AW)) bus ();
  spad_seq #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scratchpad: synchronous write, read data one cycle after ren, garbage otherwise.
  always @(posedge clk) begin
    if (bus.spad_wen) mem[bus.spad_w_addr] <= bus.spad_w_data;
    bus.spad_r_data <= bus.spad_ren ? mem[bus.spad_r_addr] : word_t'($urandom);
  end

  always @(negedge clk) begin
    if (bus.spad_wen) begin
      w_addr_q.push_back(int'(bus.spad_w_addr));
      w_data_q.push_back(bus.spad_w_data);
    end
    if (bus.spad_ren) begin
      iss_cyc_q.push_back(cyc);
      iss_addr_q.push_back(int'(bus.spad_r_addr));
      if (!bus.out_ready) ren_no_rdy++;
    end
    if (bus.out_valid) begin
      out_cyc_q.push_back(cyc);
      out_dat_q.push_back(bus.out_data);
    end
    if (bus.done) done_cyc_q.push_back(cyc);
    if (bus.spad_wen && bus.spad_ren) overlap++;
    if (bus.busy) busy_cnt++;
  end

  task automatic clear_mon();
    w_addr_q.delete(); w_data_q.delete(); iss_cyc_q.delete(); iss_addr_q.delete();
    out_cyc_q.delete(); out_dat_q.delete(); done_cyc_q.delete();
    overlap = 0; ren_no_rdy = 0; busy_cnt = 0; in_rdy_read = 0;
  endtask

  task automatic start_job(input int n, input int rr);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.len   = len_t'(n);
`ifdef SPAD_SEQ_REUSE_EN
    bus.reuse = rr[7:0];
`endif
    last_reuse = rr;
    start_cyc  = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Feeds words with optional gaps; start is toggled meanwhile and must be ignored.
  task automatic fill_words(input word_t d[$], input int gap_pct, input int gap_at);
    int i = 0;
    int guard = 0;
    bit gapped = 1'b0;
    logic rdy;
    while (i < d.size() && guard < 5000) begin
      bus.in_valid = ($urandom_range(99) >= gap_pct);
      if (i == gap_at && !gapped) begin
        bus.in_valid = 1'b0;
        gapped = 1'b1;
      end
      bus.in_data = d[i];
      bus.start   = 1'($urandom_range(1));
      bus.len     = len_t'($urandom_range(DEPTH));
      rdy = bus.in_ready;
      @(posedge clk); #1;
      if (bus.in_valid && rdy) i++;
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    bus.len      = '0;
    checks++;
    if (i != d.size()) begin
      errors++;
      $display("FAIL fill_beats accepted %0d want %0d", i, d.size());
    end
  endtask

  task automatic read_phase(input int mode, input int budget);
    int k = 0;
    while (done_cyc_q.size() == 0 && k < budget) begin
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (k % 2 == 0);
        default: bus.out_ready = 1'($urandom_range(1));
      endcase
      if (bus.in_ready) in_rdy_read++;
      @(posedge clk); #1;
      k++;
    end
    bus.out_ready = 1'b0;
    checks++;
    if (done_cyc_q.size() == 0) begin
      errors++;
      $display("FAIL done_timeout no done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    checks++; if (bus.spad_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b want 0", bus.spad_wen); end
    checks++; if (bus.spad_ren !== 1'b0) begin errors++; $display("FAIL reset_ren got %b want 0", bus.spad_ren); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.spad_w_addr !== '0) begin errors++; $display("FAIL reset_w_addr got %0h want 0", bus.spad_w_addr); end
    checks++; if (bus.spad_r_addr !== '0) begin errors++; $display("FAIL reset_r_addr got %0h want 0", bus.spad_r_addr); end
    checks++; if (bus.spad_w_data !== '0) begin errors++; $display("FAIL reset_w_data got %0h want 0", bus.spad_w_data); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data got %0h want 0", bus.out_data); end
  endtask

  task automatic test_zero_len();
    clear_mon();
    start_job(0, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cyc_q.size() != 1) begin
      errors++; $display("FAIL zero_done_count got %0d want 1", done_cyc_q.size());
    end else begin
      checks++;
      if (done_cyc_q[0] != start_cyc + 1) begin
        errors++; $display("FAIL zero_done_cycle got %0d want %0d", done_cyc_q[0], start_cyc + 1);
      end
    end
    checks++; if (w_addr_q.size() != 0) begin errors++; $display("FAIL zero_wen got %0d writes want 0", w_addr_q.size()); end
    checks++; if (iss_cyc_q.size() != 0) begin errors++; $display("FAIL zero_ren got %0d reads want 0", iss_cyc_q.size()); end
    checks++; if (busy_cnt != 0) begin errors++; $display("FAIL zero_busy got %0d busy cycles want 0", busy_cnt); end
  endtask

  task automatic test_basic();
    word_t d[$];
    d = '{32'd100, 32'd200, 32'd300};
    clear_mon();
    start_job(3, 0);
    fill_words(d, 0, 1);
    read_phase(0, 50);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", bus.busy); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (w_addr_q.size() != 3) begin errors++; $display("FAIL basic_wcount got %0d want 3", w_addr_q.size()); end
    for (int i = 0; i < 3 && i < w_addr_q.size(); i++) begin
      checks++;
      if (w_addr_q[i] != i || w_data_q[i] !== d[i]) begin
        errors++; $display("FAIL basic_write[%0d] got a=%0d d=%0d want a=%0d d=%0d", i, w_addr_q[i], w_data_q[i], i, d[i]);
      end
    end
    checks++; if (out_dat_q.size() != 3) begin errors++; $display("FAIL basic_ocount got %0d want 3", out_dat_q.size()); end
    for (int i = 0; i < 3 && i < out_dat_q.size(); i++) begin
      checks++;
      if (out_dat_q[i] !== d[i]) begin errors++; $display("FAIL basic_out[%0d] got %0d want %0d", i, out_dat_q[i], d[i]); end
      if (i > 0) begin
        checks++;
        if (out_cyc_q[i] != out_cyc_q[i-1] + 1) begin
          errors++; $display("FAIL basic_consecutive[%0d] got cycle %0d want %0d", i, out_cyc_q[i], out_cyc_q[i-1] + 1);
        end
      end
    end
    checks++;
    if (done_cyc_q.size() != 1 || out_cyc_q.size() == 0 || done_cyc_q[0] != out_cyc_q[out_cyc_q.size()-1]) begin
      errors++; $display("FAIL basic_done pulses=%0d want exactly 1 on last out_valid", done_cyc_q.size());
    end
  endtask

  task automatic test_toggle();
    word_t d[$];
    for (int i = 0; i < 4; i++) d.push_back(word_t'($urandom));
    clear_mon();
    start_job(4, 0);
    fill_words(d, 20, -1);
    read_phase(1, 60);
    checks++; if (iss_cyc_q.size() != 4) begin errors++; $display("FAIL toggle_issues got %0d want 4", iss_cyc_q.size()); end
    checks++; if (ren_no_rdy != 0) begin errors++; $display("FAIL toggle_ren_without_ready got %0d want 0", ren_no_rdy); end
    for (int i = 1; i < iss_cyc_q.size(); i++) begin
      checks++;
      if (iss_cyc_q[i] - iss_cyc_q[i-1] != 2) begin
        errors++; $display("FAIL toggle_spacing[%0d] got %0d want 2", i, iss_cyc_q[i] - iss_cyc_q[i-1]);
      end
    end
    checks++; if (out_dat_q.size() != 4) begin errors++; $display("FAIL toggle_ocount got %0d want 4", out_dat_q.size()); end
    for (int i = 0; i < 4 && i < out_dat_q.size() && i < iss_cyc_q.size(); i++) begin
      checks++;
      if (out_dat_q[i] !== d[i] || out_cyc_q[i] != iss_cyc_q[i] + 2) begin
        errors++; $display("FAIL toggle_out[%0d] got d=%0h c=%0d want d=%0h c=%0d", i, out_dat_q[i], out_cyc_q[i], d[i], iss_cyc_q[i] + 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    word_t d[$];
    for (int i = 0; i < 5; i++) d.push_back(word_t'($urandom));
    clear_mon();
    start_job(5, 0);
    fill_words(d, 0, -1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", bus.busy); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL mid_out_data got %0h want 0", bus.out_data); end
    checks++; if (bus.spad_w_addr !== '0) begin errors++; $display("FAIL mid_w_addr got %0h want 0", bus.spad_w_addr); end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 bus.out_ready = 1'b0;
    checks++; if (iss_cyc_q.size() != 2) begin errors++; $display("FAIL mid_issues got %0d want 2", iss_cyc_q.size()); end
    checks++; if (out_dat_q.size() != 1) begin errors++; $display("FAIL mid_out_count got %0d want 1", out_dat_q.size()); end
    checks++; if (done_cyc_q.size() != 0) begin errors++; $display("FAIL mid_done got %0d pulses want 0", done_cyc_q.size()); end
    d.delete();
    d.push_back(word_t'($urandom));
    clear_mon();
    start_job(1, 0);
    fill_words(d, 0, -1);
    read_phase(0, 20);
    checks++;
    if (out_dat_q.size() != 1 || out_dat_q[0] !== d[0]) begin
      errors++; $display("FAIL mid_after_job got %0d words want 1 word %0h", out_dat_q.size(), d[0]);
    end
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 7; j++) begin
      int n, rr;
      word_t d[$];
      word_t exp_q[$];
      n  = (j == 0) ? DEPTH : int'($urandom_range(1, 24));
      rr = int'($urandom_range(REUSE_MAX));
      for (int i = 0; i < n; i++) d.push_back(word_t'($urandom));
      for (int p = 0; p <= rr; p++)
        for (int i = 0; i < n; i++) exp_q.push_back(d[i]);
      repeat ($urandom_range(3)) @(posedge clk);
      clear_mon();
      start_job(n, rr);
      fill_words(d, 30, -1);
      read_phase(2, n * (rr + 1) * 8 + 50);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_busy got %b want 0", j, bus.busy); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (w_addr_q.size() != n) begin errors++; $display("FAIL rnd%0d_wcount got %0d want %0d", j, w_addr_q.size(), n); end
      for (int i = 0; i < n && i < w_addr_q.size(); i++) begin
        checks++;
        if (w_addr_q[i] != i || w_data_q[i] !== d[i]) begin
          errors++; $display("FAIL rnd%0d_write[%0d] got a=%0d d=%0h want a=%0d d=%0h", j, i, w_addr_q[i], w_data_q[i], i, d[i]);
        end
      end
      checks++;
      if (out_dat_q.size() != exp_q.size() || iss_cyc_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rnd%0d_count got out=%0d iss=%0d want %0d", j, out_dat_q.size(), iss_cyc_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < out_dat_q.size() && k < iss_cyc_q.size(); k++) begin
        checks++;
        if (out_dat_q[k] !== exp_q[k] || out_cyc_q[k] != iss_cyc_q[k] + 2 || iss_addr_q[k] != k % n) begin
          errors++;
          $display("FAIL rnd%0d_out[%0d] got d=%0h c=%0d a=%0d want d=%0h c=%0d a=%0d", j, k,
                   out_dat_q[k], out_cyc_q[k], iss_addr_q[k], exp_q[k], iss_cyc_q[k] + 2, k % n);
        end
      end
      checks++;
      if (done_cyc_q.size() != 1 || out_cyc_q.size() == 0 || done_cyc_q[0] != out_cyc_q[out_cyc_q.size()-1]) begin
        errors++; $display("FAIL rnd%0d_done pulses=%0d want exactly 1 on last out_valid", j, done_cyc_q.size());
      end
      checks++;
      if (overlap != 0 || ren_no_rdy != 0 || in_rdy_read != 0) begin
        errors++; $display("FAIL rnd%0d_ctrl got overlap=%0d ren_no_rdy=%0d in_rdy_read=%0d want 0 0 0", j, overlap, ren_no_rdy, in_rdy_read);
      end
    end
  endtask

`ifdef SPAD_SEQ_REUSE_EN
  task automatic test_reuse();
    word_t d[$];
    word_t exp_q[$];
    d     = '{32'd7, 32'd9};
    exp_q = '{32'd7, 32'd9, 32'd7, 32'd9, 32'd7, 32'd9};
    clear_mon();
    start_job(2, 2);
    fill_words(d, 0, -1);
    read_phase(0, 60);
    checks++; if (out_dat_q.size() != 6) begin errors++; $display("FAIL reuse_count got %0d want 6", out_dat_q.size()); end
    for (int k = 0; k < 6 && k < out_dat_q.size(); k++) begin
      checks++;
      if (out_dat_q[k] !== exp_q[k]) begin errors++; $display("FAIL reuse_out[%0d] got %0d want %0d", k, out_dat_q[k], exp_q[k]); end
    end
  endtask
`endif

  initial begin
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
`ifdef SPAD_SEQ_REUSE_EN
    bus.reuse = '0;
`endif
    test_reset();
    test_zero_len();
    test_basic();
    test_toggle();
    test_reset_mid();
`ifdef SPAD_SEQ_REUSE_EN
    test_reuse();
`endif
    test_random_jobs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/spad_seq.md
SPAD_SEQ -- requirements
Module: spad_seq

Interface
REQ-001 Parameter D_WIDTH, default 32, SPad word width.
REQ-002 Parameter A_WIDTH, default 8, SPad address width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  begin fill/read job; sampled only in IDLE.
REQ-006 len  in  A_WIDTH+1  words per job; legal range 0..2^A_WIDTH; latched on accepted start.
REQ-007 in_valid / in_ready / in_data  in / out / D_WIDTH  upstream global-buffer stream; valid/ready handshake.
REQ-008 spad_wen / spad_w_addr / spad_w_data  out / out / A_WIDTH / D_WIDTH  SPad write port.
REQ-009 spad_ren / spad_r_addr  out / out / 1 / A_WIDTH  SPad read port.
REQ-010 spad_r_data  in  D_WIDTH  SPad read data; valid exactly 1 cycle after spad_ren.
REQ-011 out_ready  in  1  consumer (MAC) can take a word two cycles later.
REQ-012 out_valid / out_data  out / D_WIDTH  word delivered to consumer.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse at job end.

Function
REQ-015 FSM states: IDLE, FILL, READ, DRAIN; IDLE->FILL on start with len>0; start with len=0 SHALL pulse done on the next cycle and remain in IDLE.
REQ-016 FILL: in_ready=1; each in_valid&in_ready cycle SHALL drive spad_wen=1, spad_w_data=in_data, spad_w_addr=write counter, combinationally in that same cycle, then increment the counter.
REQ-017 FILL->READ in the cycle after the len-th beat; in_ready SHALL be 0 outside FILL.
REQ-018 READ: spad_ren=out_ready, spad_r_addr=read counter; the counter increments only on issue.
REQ-019 Read latency: out_valid SHALL assert exactly 2 cycles after issue, out_data=spad_r_data registered once; no reordering.
REQ-020 The consumer SHALL accept every out_valid word; the block has no output back-pressure beyond out_ready at issue.
REQ-021 After the last issue, READ->DRAIN; DRAIN->IDLE once the final out_valid has been asserted, with done pulsed in that same cycle.
REQ-022 len=2^A_WIDTH: address SHALL wrap from 2^A_WIDTH-1 only at job end; no address is written twice in one job.
REQ-023 spad_wen and spad_ren SHALL never be asserted in the same cycle.
REQ-024 start while busy SHALL be ignored.

Reset
REQ-025 rst high at a clock edge SHALL force IDLE, clear the counters and the pipeline, and force in_ready, spad_wen, spad_ren, out_valid, done and busy to 0, and spad_w_addr, spad_r_addr, spad_w_data and out_data to 0.
REQ-026 Reset mid-job SHALL abort the job: no done pulse and no further out_valid; in-flight reads are discarded.

Configuration
REQ-027 Macro SPAD_SEQ_REUSE_EN: when defined, an extra input reuse (8 bits, latched with start) SHALL cause READ to replay the full 0..len-1 address sequence reuse+1 times before DRAIN; reuse=0 gives a single pass.
REQ-028 Without SPAD_SEQ_REUSE_EN, the reuse port SHALL be absent and exactly one read pass SHALL occur.

Verification
REQ-029 Reset, then idle for 3 cycles -> all outputs 0, busy=0.
REQ-030 start with len=3; stream values 100, 200, 300 with one in_valid gap; out_ready=1 -> writes to addresses 0, 1, 2; out_data = 100, 200, 300 on consecutive cycles; done pulses once; busy returns to 0.
REQ-031 len=4 with out_ready toggling 1,0,1,0,... -> reads issued only when out_ready=1; each out_valid occurs 2 cycles after its issue; data in order.
REQ-032 len=0 start -> done pulse next cycle; no wen, no ren.
REQ-033 Assert rst during READ after 2 of 5 issues -> out_valid drops within 1 cycle; no done pulse; a subsequent len=1 job completes normally.
REQ-034 With SPAD_SEQ_REUSE_EN, len=2, reuse=2, data 7, 9 -> out_data sequence 7, 9, 7, 9, 7, 9, then done.
